// File: rtl/gpio_pad_pkg.sv
// Shared constants for the GPIO pad controller:
// register word indices, reset values and bus width.
package gpio_pad_pkg;

  localparam int RDATA_W = 32;

  localparam logic [2:0] IDX_OUT  = 3'd0;
  localparam logic [2:0] IDX_DIR  = 3'd1;
  localparam logic [2:0] IDX_ODRN = 3'd2;
  localparam logic [2:0] IDX_IN   = 3'd3;
  localparam logic [2:0] IDX_RISE = 3'd4;
  localparam logic [2:0] IDX_FALL = 3'd5;
  localparam logic [2:0] IDX_PEND = 3'd6;
  localparam logic [2:0] IDX_RSVD = 3'd7;

  localparam logic [RDATA_W-1:0] REG_RST  = '0;
  localparam logic [RDATA_W-1:0] PADT_RST = '1;

endpackage

// File: rtl/gpio_pad_sync_db.sv
// Pad input conditioning: 2-FF synchroniser, optional tick debounce.
// Ports: clk_i, rstn_i, pad_i (async pad levels), filt_o (clean levels).
module gpio_pad_sync_db
  import gpio_pad_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 0,
  parameter int DB_W      = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] filt_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_q <= REG_RST[WIDTH-1:0];
      s2_q <= REG_RST[WIDTH-1:0];
    end else begin
      s1_q <= pad_i;
      s2_q <= s1_q;
    end
  end

  if (DB_CYCLES == 0) begin : g_bypass
    assign filt_o = s2_q;
  end else begin : g_db
    localparam logic [DB_W-1:0] LAST = DB_W'(DB_CYCLES - 1);

    logic [DB_W-1:0]  cnt_q;
    logic [DB_W-1:0]  cnt_d;
    logic             tick;
    logic [WIDTH-1:0] samp_q;
    logic [WIDTH-1:0] filt_q;
    logic [WIDTH-1:0] filt_d;
    logic [WIDTH-1:0] agree;

    assign tick  = (cnt_q == LAST);
    assign cnt_d = tick ? '0 : cnt_q + DB_W'(1);

    // A pin follows the pad only when this tick's sample
    // matches the previous tick's sample.
    assign agree  = ~(samp_q ^ s2_q);
    assign filt_d = (agree & s2_q) | (~agree & filt_q);

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        cnt_q  <= '0;
        samp_q <= REG_RST[WIDTH-1:0];
        filt_q <= REG_RST[WIDTH-1:0];
      end else begin
        cnt_q <= cnt_d;
        if (tick) begin
          samp_q <= s2_q;
          filt_q <= filt_d;
        end
      end
    end

    assign filt_o = filt_q;
  end

endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: register file, tri-state drive, edge IRQs.
// Ports: clk/rstn, 1-cycle-ack bus, pad_t/pad_i to buffer, pad_o from it, irq.
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 0,
  parameter int DB_W      = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               bus_req_i,
  input  logic               bus_we_i,
  input  logic [2:0]         bus_addr_i,
  input  logic [31:0]        bus_wdata_i,
  output logic [RDATA_W-1:0] bus_rdata_o,
  output logic               bus_ack_o,
  output logic [WIDTH-1:0]   pad_t_o,
  output logic [WIDTH-1:0]   pad_i_o,
  input  logic [WIDTH-1:0]   pad_o_i,
  output logic               irq_o
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] odrn_q, odrn_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] pad_t_q, pad_i_q;
  logic [WIDTH-1:0] filt, clr, set, wdat;
  logic [RDATA_W-1:0] rdata_q, rdata_d, rd;
  logic ack_q, irq_q, wr;
  logic unused_wdata;

  gpio_pad_sync_db #(
    .WIDTH    (WIDTH),
    .DB_CYCLES(DB_CYCLES),
    .DB_W     (DB_W)
  ) u_sync (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .pad_i (pad_o_i),
    .filt_o(filt)
  );

  assign wr           = bus_req_i & bus_we_i;
  assign wdat         = bus_wdata_i[WIDTH-1:0];
  assign unused_wdata = ^bus_wdata_i;

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    odrn_d = odrn_q;
    rise_d = rise_q;
    fall_d = fall_q;
    clr    = '0;
    if (wr) begin
      unique case (bus_addr_i)
        IDX_OUT:  out_d  = wdat;
        IDX_DIR:  dir_d  = wdat;
        IDX_ODRN: odrn_d = wdat;
        IDX_RISE: rise_d = wdat;
        IDX_FALL: fall_d = wdat;
        IDX_PEND: clr    = wdat;
        default:  ;
      endcase
    end
  end

  // A new edge beats a simultaneous write-1-to-clear.
  assign set    = (filt & ~prev_q & rise_q)
                | (~filt & prev_q & fall_q);
  assign pend_d = (pend_q & ~clr) | set;

  always_comb begin
    rd = '0;
    unique case (bus_addr_i)
      IDX_OUT:  rd[WIDTH-1:0] = out_q;
      IDX_DIR:  rd[WIDTH-1:0] = dir_q;
      IDX_ODRN: rd[WIDTH-1:0] = odrn_q;
      IDX_IN:   rd[WIDTH-1:0] = filt;
      IDX_RISE: rd[WIDTH-1:0] = rise_q;
      IDX_FALL: rd[WIDTH-1:0] = fall_q;
      IDX_PEND: rd[WIDTH-1:0] = pend_q;
      default:  rd = '0;
    endcase
  end

  assign rdata_d = (bus_req_i & ~bus_we_i) ? rd : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_q   <= REG_RST[WIDTH-1:0];
      dir_q   <= REG_RST[WIDTH-1:0];
      odrn_q  <= REG_RST[WIDTH-1:0];
      rise_q  <= REG_RST[WIDTH-1:0];
      fall_q  <= REG_RST[WIDTH-1:0];
      pend_q  <= REG_RST[WIDTH-1:0];
      prev_q  <= REG_RST[WIDTH-1:0];
      pad_t_q <= PADT_RST[WIDTH-1:0];
      pad_i_q <= REG_RST[WIDTH-1:0];
      rdata_q <= REG_RST;
      ack_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      odrn_q  <= odrn_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pend_q  <= pend_d;
      prev_q  <= filt;
      // Open-drain pins release the pad instead of driving high.
      pad_t_q <= ~dir_d | (odrn_d & out_d);
      pad_i_q <= out_d;
      rdata_q <= rdata_d;
      ack_q   <= bus_req_i;
      irq_q   <= |pend_q;
    end
  end

  assign bus_rdata_o = rdata_q;
  assign bus_ack_o   = ack_q;
  assign pad_t_o     = pad_t_q;
  assign pad_i_o     = pad_i_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Self-checking bench for gpio_pad_ctrl: vector table, scoreboard,
// edge IRQ, W1C race, debounce and mid-access reset sequences.
module tb_gpio_pad_ctrl;
  import gpio_pad_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [7:0]  pad;
  logic [31:0] rd0, rd1;
  logic        ack0, ack1, irq0, irq1;
  logic [7:0]  t0, i0, t1, i1;

  int nchk = 0;
  int nerr = 0;
  int cyc;
  logic req_seen;

  typedef struct {
    logic        chk;
    logic        sel;
    logic [31:0] exp;
    string       nm;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic        we;
    logic [2:0]  idx;
    logic [31:0] wd;
    logic [31:0] exp;
    logic [7:0]  t;
    logic [7:0]  pi;
    string       nm;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  gpio_pad_ctrl #(.WIDTH(8), .DB_CYCLES(0), .DB_W(16)) u_dut (
    .clk_i(clk), .rstn_i(rstn),
    .bus_req_i(req), .bus_we_i(we), .bus_addr_i(addr),
    .bus_wdata_i(wdata), .bus_rdata_o(rd0), .bus_ack_o(ack0),
    .pad_t_o(t0), .pad_i_o(i0), .pad_o_i(pad), .irq_o(irq0)
  );

  gpio_pad_ctrl #(.WIDTH(8), .DB_CYCLES(4), .DB_W(16)) u_db (
    .clk_i(clk), .rstn_i(rstn),
    .bus_req_i(req), .bus_we_i(we), .bus_addr_i(addr),
    .bus_wdata_i(wdata), .bus_rdata_o(rd1), .bus_ack_o(ack1),
    .pad_t_o(t1), .pad_i_o(i1), .pad_o_i(pad), .irq_o(irq1)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      cyc      <= 0;
      req_seen <= 1'b0;
    end else begin
      cyc      <= cyc + 1;
      req_seen <= req;
    end

  // Scoreboard: every ack pops one entry; reads compare rdata.
  always @(negedge clk) begin
    if (rstn) begin
      if (ack0 || ack1 || req_seen) begin
        chk("ack_timing", {30'd0, ack1, ack0}, {30'd0, req_seen, req_seen});
      end
      if (ack0) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          if (e.chk) chk(e.nm, e.sel ? rd1 : rd0, e.exp);
        end
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic w, input logic [2:0] a,
                       input logic [31:0] d, input logic sel,
                       input logic [31:0] exp, input string nm);
    sb_t e;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    e.chk = ~w; e.sel = sel; e.exp = exp; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    issue(1'b1, a, d, 1'b0, 32'd0, "wr");
    idle();
  endtask

  task automatic rdc(input logic [2:0] a, input logic sel,
                     input logic [31:0] exp, input string nm);
    issue(1'b0, a, 32'd0, sel, exp, nm);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    pad = 8'hA5;

    tbl.push_back('{1'b0, IDX_IN,   32'h0,        32'hA5, 8'hFF, 8'h00, "rd_in_a5"});
    tbl.push_back('{1'b1, IDX_DIR,  32'h0F,       32'h0,  8'hF0, 8'h00, "wr_dir"});
    tbl.push_back('{1'b1, IDX_OUT,  32'h05,       32'h0,  8'hF0, 8'h05, "wr_out"});
    tbl.push_back('{1'b1, IDX_ODRN, 32'h01,       32'h0,  8'hF1, 8'h05, "wr_odrn"});
    tbl.push_back('{1'b0, IDX_DIR,  32'h0,        32'h0F, 8'hF1, 8'h05, "rd_dir"});
    tbl.push_back('{1'b0, IDX_OUT,  32'h0,        32'h05, 8'hF1, 8'h05, "rd_out"});
    tbl.push_back('{1'b0, IDX_ODRN, 32'h0,        32'h01, 8'hF1, 8'h05, "rd_odrn"});
    tbl.push_back('{1'b1, IDX_OUT,  32'hFFFFFF04, 32'h0,  8'hF0, 8'h04, "wr_out_wide"});
    tbl.push_back('{1'b0, IDX_OUT,  32'h0,        32'h04, 8'hF0, 8'h04, "rd_out_mask"});
    tbl.push_back('{1'b1, IDX_RSVD, 32'hFFFFFFFF, 32'h0,  8'hF0, 8'h04, "wr_rsvd"});
    tbl.push_back('{1'b0, IDX_RSVD, 32'h0,        32'h0,  8'hF0, 8'h04, "rd_rsvd"});
    tbl.push_back('{1'b1, IDX_IN,   32'hFF,       32'h0,  8'hF0, 8'h04, "wr_in_ro"});
    tbl.push_back('{1'b0, IDX_IN,   32'h0,        32'hA5, 8'hF0, 8'h04, "rd_in_ro"});
    tbl.push_back('{1'b1, IDX_ODRN, 32'h0,        32'h0,  8'hF0, 8'h04, "wr_odrn0"});

    wait_n(3);
    chk("rst_pad_t", {24'd0, t0}, 32'hFF);
    chk("rst_pad_i", {24'd0, i0}, 32'h00);
    chk("rst_irq",   {31'd0, irq0}, 32'd0);
    chk("rst_ack",   {31'd0, ack0}, 32'd0);
    rstn = 1'b1;
    wait_n(3);

    foreach (tbl[k]) begin
      issue(tbl[k].we, tbl[k].idx, tbl[k].wd, 1'b0, tbl[k].exp, tbl[k].nm);
      idle();
      chk({tbl[k].nm, "_pad_t"}, {24'd0, t0}, {24'd0, tbl[k].t});
      chk({tbl[k].nm, "_pad_i"}, {24'd0, i0}, {24'd0, tbl[k].pi});
    end

    // Back-to-back reads.
    issue(1'b0, IDX_DIR, 32'd0, 1'b0, 32'h0F, "b2b_dir");
    issue(1'b0, IDX_OUT, 32'd0, 1'b0, 32'h04, "b2b_out");
    idle();

    // Rising edge on pin 7 raises the IRQ on the 4th edge.
    pad = 8'h25;
    wait_n(5);
    wr(IDX_RISE, 32'h80);
    @(negedge clk); pad = 8'hA5;
    wait_n(3);
    chk("irq_e3", {31'd0, irq0}, 32'd0);
    wait_n(1);
    chk("irq_e4", {31'd0, irq0}, 32'd1);
    rdc(IDX_PEND, 1'b0, 32'h80, "pend_rise");
    wr(IDX_PEND, 32'h80);
    chk("irq_w1c_n1", {31'd0, irq0}, 32'd1);
    wait_n(1);
    chk("irq_w1c_n2", {31'd0, irq0}, 32'd0);
    rdc(IDX_PEND, 1'b0, 32'h00, "pend_clr");

    // W1C coinciding with a new rise: set wins.
    pad = 8'h25; wait_n(5);
    pad = 8'hA5; wait_n(5);
    chk("race_pre_irq", {31'd0, irq0}, 32'd1);
    pad = 8'h25; wait_n(5);
    @(negedge clk); pad = 8'hA5;
    wait_n(1);
    issue(1'b1, IDX_PEND, 32'h80, 1'b0, 32'd0, "w1c_race");
    idle();
    chk("race_irq_0", {31'd0, irq0}, 32'd1);
    wait_n(1);
    chk("race_irq_1", {31'd0, irq0}, 32'd1);
    wait_n(1);
    chk("race_irq_2", {31'd0, irq0}, 32'd1);
    rdc(IDX_PEND, 1'b0, 32'h80, "race_pend");

    // Debounce instance (DB_CYCLES=4).
    pad = 8'h00;
    wait_n(20);
    wr(IDX_RISE, 32'h04);
    wr(IDX_FALL, 32'h04);
    wr(IDX_PEND, 32'hFF);
    rdc(IDX_PEND, 1'b1, 32'h00, "db_pend_init");
    // Align the glitch so exactly one tick samples it.
    while (cyc % 4 != 2) @(negedge clk);
    pad = 8'h04;
    wait_n(5);
    pad = 8'h00;
    wait_n(16);
    rdc(IDX_IN,   1'b1, 32'h00, "db_glitch_in");
    rdc(IDX_PEND, 1'b1, 32'h00, "db_glitch_pend");
    pad = 8'h04;
    wait_n(16);
    rdc(IDX_IN,   1'b1, 32'h04, "db_hold_in");
    rdc(IDX_PEND, 1'b1, 32'h04, "db_rise_pend");
    chk("db_irq", {31'd0, irq1}, 32'd1);
    wr(IDX_PEND, 32'h04);
    pad = 8'h00;
    wait_n(16);
    rdc(IDX_IN,   1'b1, 32'h00, "db_fall_in");
    rdc(IDX_PEND, 1'b1, 32'h04, "db_fall_pend");

    // Reset in the middle of an access.
    wr(IDX_DIR, 32'hFF);
    chk("dir_ff_pad_t", {24'd0, t0}, 32'h00);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = IDX_DIR;
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 chk("mid_rst_pad_t", {24'd0, t0}, 32'hFF);
    chk("mid_rst_ack", {31'd0, ack0}, 32'd0);
    @(negedge clk); req = 1'b0;
    chk("mid_rst_ack2", {31'd0, ack0}, 32'd0);
    wait_n(2);
    rstn = 1'b1;
    wait_n(1);
    chk("post_rst_ack", {31'd0, ack0}, 32'd0);
    chk("post_rst_irq", {31'd0, irq0}, 32'd0);
    rdc(IDX_PEND, 1'b0, 32'h00, "post_rst_pend");
    rdc(IDX_DIR,  1'b0, 32'h00, "post_rst_dir");
    chk("post_rst_pad_t", {24'd0, t0}, 32'hFF);

    wait_n(3);
    chk("sb_drained", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
